lsu_rv32i: RTL and testbench
============================

Name: lsu_rv32i

Overview:
Load/store unit sitting directly downstream of the control unit in the RV32I core. It consumes the decoded memory-access controls (cu_store, cu_storetype, cu_loadtype, and the load condition rdtype = from-memory) together with the ALU-computed address and rs2 data. It runs a request/ready/rvalid handshake to a word-wide data memory with byte enables, aligns store data, and sign- or zero-extends load data. It reports completion, busy and misalignment back to the core so the core can stall its writeback.

Parameters:
ADDR_W, 32, width of lsu_addr and mem_addr
DATA_W, 32, data width; fixed at 32 for RV32I, not to be changed

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
lsu_valid  in  1  core requests an access; held high until lsu_done
lsu_load  in  1  access is a load (cu_rdtype = 2'b01)
lsu_store  in  1  access is a store (cu_store)
lsu_loadtype  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
lsu_storetype  in  2  00 SB, 01 SH, 10 SW
lsu_addr  in  32  byte address from ALU
lsu_wdata  in  32  store data (rs2)
lsu_rdata  out  32  extended load result
lsu_done  out  1  one-cycle completion pulse
lsu_busy  out  1  high whenever FSM is not IDLE
lsu_misalign  out  1  one-cycle pulse with lsu_done when the access was misaligned
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset: FSM = IDLE; all outputs 0, including lsu_rdata. Reset in any state aborts the transaction. mem_req is 0 after the reset edge. An mem_rvalid that arrives later is ignored.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: on lsu_valid & (lsu_load | lsu_store), latch address, data, type and op.
  - If both lsu_load and lsu_store are high, the access is a store.
  - lsu_valid with neither op high is ignored and leaves the FSM in IDLE.
  - Alignment check at acceptance: half requires addr[0] = 0; word requires addr[1:0] = 0; byte is always aligned.
  - Misaligned -> ERR. Aligned -> REQ.
- ERR: lsu_done = 1 and lsu_misalign = 1 for one cycle; no memory access; lsu_rdata unchanged; -> IDLE.
- REQ: mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are stable from entry until accepted.
  - On mem_ready: a store -> DONE; a load -> WAIT.
- WAIT: on mem_rvalid, capture the extended data into lsu_rdata -> DONE. mem_rvalid is only sampled in WAIT.
- DONE: lsu_done = 1 for one cycle -> IDLE. A new request can be accepted on the following cycle.
- Minimum latency (valid seen in cycle 0):
  - Store: REQ in cycle 1, lsu_done in cycle 2.
  - Load: REQ in cycle 1, WAIT in cycle 2 with rvalid, lsu_done in cycle 3.
- Store lane alignment, with k = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, be = 4'b0001 << k.
  - SH: wdata = {2{wdata[15:0]}}, be = 4'b0011 << k.
  - SW: wdata = wdata, be = 4'b1111.
  - storetype 11 is treated as SW.
- Load extraction: shifted = mem_rdata >> (8*k).
  - LB sign-extends shifted[7:0]; LBU zero-extends it.
  - LH sign-extends shifted[15:0]; LHU zero-extends it.
  - LW takes the full 32 bits.
  - loadtype 101-111 are treated as LW.
- lsu_rdata holds its value until the next successful load; stores and misaligned accesses do not alter it.
- Loads drive mem_we = 0 and mem_be = 4'b1111.
- mem_addr = {addr[31:2], 2'b00}.

Test Plan:
- Reset then SW addr 0x100, wdata 0xDEADBEEF, mem_ready high -> mem_req in cycle 1 with mem_we = 1, mem_addr 0x100, be 1111, wdata 0xDEADBEEF; lsu_done in cycle 2; lsu_busy high for cycles 1-2.
- SB addr 0x203, wdata 0x000000A5 -> be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x200.
- LB addr 0x301, mem_rdata 0x12348000 with rvalid 2 cycles after ready -> lsu_rdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH addr 0x402, mem_rdata 0x8001FFFF -> 0xFFFF8001. LW addr 0x406 -> no mem_req, lsu_done & lsu_misalign pulse 1 cycle after acceptance, lsu_rdata unchanged.
- mem_ready low for 5 cycles during SH addr 0x10 -> mem_req and all mem_* held stable; lsu_done exactly 1 cycle after ready.
- Assert reset while in WAIT, then drive mem_rvalid -> FSM IDLE, no lsu_done, lsu_rdata = 0.

Source files
------------

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: accepts decoded memory ops from the core, drives a
// req/ready/rvalid word memory with byte enables and returns extended load data.
module lsu_rv32i #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              lsu_load,
    input  logic              lsu_store,
    input  logic [2:0]        lsu_loadtype,
    input  logic [1:0]        lsu_storetype,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_busy,
    output logic              lsu_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [1:0] storetype,
                                           input logic [2:0] loadtype,
                                           input logic [1:0] k);
        logic result;
        result = 1'b0;
        if (is_store) begin
            case (storetype)
                2'b00:   result = 1'b0;
                2'b01:   result = k[0];
                default: result = (k != 2'b00);
            endcase
        end else begin
            case (loadtype)
                3'b000, 3'b011: result = 1'b0;
                3'b001, 3'b100: result = k[0];
                default:        result = (k != 2'b00);
            endcase
        end
        return result;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] storetype,
                                            input logic [1:0] k);
        logic [3:0] result;
        case (storetype)
            2'b00:   result = 4'b0001 << k;
            2'b01:   result = 4'b0011 << k;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

    // Replicating the narrow value into every lane lets the byte enables pick it out.
    function automatic logic [DATA_W-1:0] store_data(input logic [1:0]        storetype,
                                                     input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] result;
        case (storetype)
            2'b00:   result = {4{wdata[7:0]}};
            2'b01:   result = {2{wdata[15:0]}};
            default: result = wdata;
        endcase
        return result;
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rdata,
                                                      input logic [2:0]        loadtype,
                                                      input logic [1:0]        k);
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] result;
        shifted = rdata >> {k, 3'b000};
        case (loadtype)
            3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
            3'b011:  result = {24'h000000, shifted[7:0]};
            3'b100:  result = {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              misalign_s;
    logic              capture_s;
    logic              is_store_r;
    logic [2:0]        loadtype_r;
    logic [1:0]        offset_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] lsu_rdata_r;
    logic              lsu_done_r;
    logic              lsu_busy_r;
    logic              lsu_misalign_r;

    // Next-state decode; a simultaneous load+store request is taken as a store.
    always_comb begin
        next_state_s = state_r;
        accept_s     = lsu_valid & (lsu_load | lsu_store);
        misalign_s   = is_misaligned(lsu_store, lsu_storetype, lsu_loadtype, lsu_addr[1:0]);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (misalign_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (is_store_r) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        capture_s = (state_r == ST_IDLE) && (next_state_s == ST_REQ);
    end

    // State, registered handshake outputs and the latched access fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            is_store_r     <= 1'b0;
            loadtype_r     <= 3'b000;
            offset_r       <= 2'b00;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_be_r       <= 4'b0000;
            mem_wdata_r    <= {DATA_W{1'b0}};
            lsu_rdata_r    <= {DATA_W{1'b0}};
            lsu_done_r     <= 1'b0;
            lsu_busy_r     <= 1'b0;
            lsu_misalign_r <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            mem_req_r      <= (next_state_s == ST_REQ);
            lsu_done_r     <= (next_state_s == ST_DONE) || (next_state_s == ST_ERR);
            lsu_misalign_r <= (next_state_s == ST_ERR);
            lsu_busy_r     <= (next_state_s != ST_IDLE);
            if (capture_s) begin
                is_store_r  <= lsu_store;
                loadtype_r  <= lsu_loadtype;
                offset_r    <= lsu_addr[1:0];
                mem_we_r    <= lsu_store;
                mem_addr_r  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                mem_be_r    <= lsu_store ? store_be(lsu_storetype, lsu_addr[1:0]) : 4'b1111;
                mem_wdata_r <= lsu_store ? store_data(lsu_storetype, lsu_wdata) : {DATA_W{1'b0}};
            end
            if ((state_r == ST_WAIT) && mem_rvalid) begin
                lsu_rdata_r <= load_extend(mem_rdata, loadtype_r, offset_r);
            end
        end
    end

    assign lsu_rdata    = lsu_rdata_r;
    assign lsu_done     = lsu_done_r;
    assign lsu_busy     = lsu_busy_r;
    assign lsu_misalign = lsu_misalign_r;
    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_be       = mem_be_r;
    assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_lsu_rv32i.sv
// Scoreboard bench for lsu_rv32i: expected memory requests and completions are
// queued when each access is driven and compared when the DUT produces them.
module tb_lsu_rv32i;

    logic        clock;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_load;
    logic        lsu_store;
    logic [2:0]  lsu_loadtype;
    logic [1:0]  lsu_storetype;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_busy;
    logic        lsu_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } done_exp_t;

    req_exp_t    exp_req_q[$];
    done_exp_t   exp_done_q[$];
    int          checks;
    int          errors;
    logic [31:0] last_rdata;

    lsu_rv32i dut (
        .clock         (clock),
        .reset         (reset),
        .lsu_valid     (lsu_valid),
        .lsu_load      (lsu_load),
        .lsu_store     (lsu_store),
        .lsu_loadtype  (lsu_loadtype),
        .lsu_storetype (lsu_storetype),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_rdata     (lsu_rdata),
        .lsu_done      (lsu_done),
        .lsu_busy      (lsu_busy),
        .lsu_misalign  (lsu_misalign),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation for each memory handshake and each completion.
    always @(negedge clock) begin
        req_exp_t  r;
        done_exp_t d;
        if (mem_req && mem_ready) begin
            check_eq("req_pending", 32'(exp_req_q.size() > 0), 32'd1);
            if (exp_req_q.size() > 0) begin
                r = exp_req_q.pop_front();
                check_eq("req_we", 32'(mem_we), 32'(r.we));
                check_eq("req_addr", mem_addr, r.addr);
                check_eq("req_be", 32'(mem_be), 32'(r.be));
                if (r.chk_wdata) check_eq("req_wdata", mem_wdata, r.wdata);
            end
        end
        if (lsu_done) begin
            check_eq("done_pending", 32'(exp_done_q.size() > 0), 32'd1);
            if (exp_done_q.size() > 0) begin
                d = exp_done_q.pop_front();
                check_eq("done_rdata", lsu_rdata, d.rdata);
                check_eq("done_misalign", 32'(lsu_misalign), 32'(d.mis));
            end
        end
    end

    task automatic run_access(input string name, input logic ld, input logic st,
                              input logic [2:0] lt, input logic [1:0] stt,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mdata, input logic [31:0] eres,
                              input logic [3:0] ebe, input logic [31:0] ewdata,
                              input logic mis, input int rdy_dly, input int rv_dly);
        int          exp_done;
        int          cyc;
        int          req_cnt;
        int          wait_cnt;
        logic        in_wait;
        logic        done_seen;
        logic        is_load;
        logic        h_we;
        logic [31:0] h_addr;
        logic [3:0]  h_be;
        logic [31:0] h_wdata;
        is_load  = ld & ~st;
        exp_done = mis ? 1 : (is_load ? 3 + rdy_dly + rv_dly : 2 + rdy_dly);
        if (!mis) begin
            exp_req_q.push_back('{we: st, addr: {addr[31:2], 2'b00},
                                  be: is_load ? 4'hF : ebe, wdata: ewdata, chk_wdata: st});
        end
        if (is_load && !mis) last_rdata = eres;
        exp_done_q.push_back('{rdata: last_rdata, mis: mis});

        @(posedge clock); #1;
        lsu_valid     = 1'b1;
        lsu_load      = ld;
        lsu_store     = st;
        lsu_loadtype  = lt;
        lsu_storetype = stt;
        lsu_addr      = addr;
        lsu_wdata     = wdata;
        cyc = 0; req_cnt = 0; wait_cnt = 0; in_wait = 1'b0; done_seen = 1'b0;
        h_we = 1'b0; h_addr = 32'h0; h_be = 4'h0; h_wdata = 32'h0;
        while (!done_seen && cyc < 40) begin
            mem_ready  = mem_req && (req_cnt >= rdy_dly);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (in_wait) begin
                if (wait_cnt == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mdata;
                end
                wait_cnt++;
            end else if (mem_req && !mem_ready && is_load) begin
                // rvalid outside WAIT carries junk and must be ignored
                mem_rvalid = 1'b1;
                mem_rdata  = ~mdata;
            end
            @(negedge clock);
            check_eq({name, "/busy"}, 32'(lsu_busy), 32'((cyc >= 1) && (cyc <= exp_done)));
            if (mem_req) begin
                if (req_cnt == 0) begin
                    h_we = mem_we; h_addr = mem_addr; h_be = mem_be; h_wdata = mem_wdata;
                end else begin
                    check_eq({name, "/hold_we"}, 32'(mem_we), 32'(h_we));
                    check_eq({name, "/hold_addr"}, mem_addr, h_addr);
                    check_eq({name, "/hold_be"}, 32'(mem_be), 32'(h_be));
                    check_eq({name, "/hold_wdata"}, mem_wdata, h_wdata);
                end
                req_cnt++;
                if (mem_ready && is_load) in_wait = 1'b1;
            end else if (in_wait && mem_rvalid) begin
                in_wait = 1'b0;
            end
            if (lsu_done) begin
                done_seen = 1'b1;
                check_eq({name, "/done_cyc"}, 32'(cyc), 32'(exp_done));
            end else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check_eq({name, "/done_seen"}, 32'(done_seen), 32'd1);
        @(posedge clock); #1;
        lsu_valid  = 1'b0;
        lsu_load   = 1'b0;
        lsu_store  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; last_rdata = 32'h0;
        reset = 1'b1; lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0;
        lsu_loadtype = 3'b000; lsu_storetype = 2'b00; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst/rdata", lsu_rdata, 32'h0);
        check_eq("rst/done", 32'(lsu_done), 32'd0);
        check_eq("rst/busy", 32'(lsu_busy), 32'd0);
        check_eq("rst/misalign", 32'(lsu_misalign), 32'd0);
        check_eq("rst/req", 32'(mem_req), 32'd0);
        check_eq("rst/we", 32'(mem_we), 32'd0);
        check_eq("rst/addr", mem_addr, 32'h0);
        check_eq("rst/be", 32'(mem_be), 32'd0);
        check_eq("rst/wdata", mem_wdata, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        //          name    ld    st    lt      stt    addr         wdata        mdata        eres         be     ewdata       mis  rdy rv
        run_access("sw",    1'b0, 1'b1, 3'b000, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 0, 0);
        run_access("sb",    1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0, 32'h0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 0, 0);
        run_access("lb",    1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0301, 32'h0, 32'h1234_8000, 32'hFFFF_FF80, 4'b1111, 32'h0, 1'b0, 0, 1);
        run_access("lbu",   1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_0301, 32'h0, 32'h1234_8000, 32'h0000_0080, 4'b1111, 32'h0, 1'b0, 0, 1);
        run_access("lh",    1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_0402, 32'h0, 32'h8001_FFFF, 32'hFFFF_8001, 4'b1111, 32'h0, 1'b0, 0, 0);
        run_access("lw_mis",1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0406, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0);
        run_access("sh_rdy",1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0010, 32'h0000_BEEF, 32'h0, 32'h0, 4'b0011, 32'hBEEF_BEEF, 1'b0, 5, 0);
        run_access("sh_hi", 1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0012, 32'h1234_5678, 32'h0, 32'h0, 4'b1100, 32'h5678_5678, 1'b0, 0, 0);
        run_access("st11",  1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0, 0, 0);
        run_access("lhu",   1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_0002, 32'h0, 32'hABCD_1234, 32'h0000_ABCD, 4'b1111, 32'h0, 1'b0, 2, 0);
        run_access("lb_k3", 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0003, 32'h0, 32'h7F00_0000, 32'h0000_007F, 4'b1111, 32'h0, 1'b0, 0, 0);
        run_access("lt111", 1'b1, 1'b0, 3'b111, 2'b00, 32'h0000_0040, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'b1111, 32'h0, 1'b0, 0, 0);
        run_access("ldst",  1'b1, 1'b1, 3'b010, 2'b00, 32'h0000_0041, 32'h0000_0011, 32'h0, 32'h0, 4'b0010, 32'h1111_1111, 1'b0, 0, 0);
        run_access("sh_mis",1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0011, 32'h0000_2222, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0);
        run_access("lh_mis",1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_0003, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0);
        run_access("lw_slow",1'b1,1'b0, 3'b010, 2'b00, 32'h0000_0044, 32'h0, 32'h00C0_FFEE, 32'h00C0_FFEE, 4'b1111, 32'h0, 1'b0, 1, 2);

        // lsu_valid without an op must leave the unit idle
        @(posedge clock); #1;
        lsu_valid = 1'b1; lsu_load = 1'b0; lsu_store = 1'b0; lsu_addr = 32'h0000_0080;
        repeat (3) begin
            @(negedge clock);
            check_eq("noop/busy", 32'(lsu_busy), 32'd0);
            check_eq("noop/req", 32'(mem_req), 32'd0);
        end
        @(posedge clock); #1;
        lsu_valid = 1'b0;

        // reset while waiting for read data; the late rvalid must be dropped
        exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0500, be: 4'hF, wdata: 32'h0, chk_wdata: 1'b0});
        @(posedge clock); #1;
        lsu_valid = 1'b1; lsu_load = 1'b1; lsu_loadtype = 3'b010; lsu_addr = 32'h0000_0500;
        @(posedge clock); #1;
        mem_ready = mem_req;
        @(posedge clock); #1;
        mem_ready = 1'b0; lsu_valid = 1'b0; lsu_load = 1'b0;
        check_eq("rstwait/busy_before", 32'(lsu_busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clock);
        check_eq("rstwait/busy", 32'(lsu_busy), 32'd0);
        check_eq("rstwait/req", 32'(mem_req), 32'd0);
        check_eq("rstwait/rdata", lsu_rdata, 32'h0);
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_eq("rstwait/done", 32'(lsu_done), 32'd0);
            check_eq("rstwait/rdata_late", lsu_rdata, 32'h0);
            check_eq("rstwait/busy_late", 32'(lsu_busy), 32'd0);
        end

        check_eq("req_left", 32'(exp_req_q.size()), 32'd0);
        check_eq("done_left", 32'(exp_done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
